// File: rtl/burst_pkg.sv
// Shared types and helpers for the burst address sequencer.
package burst_pkg;

  // Burst mode field of the descriptor.
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_INCR   = 2'b01,
    MODE_WRAP   = 2'b10,
    MODE_FIXED  = 2'b11
  } mode_t;

  // Sequencer control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SHIFT,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Descriptor width: {mode[1:0], len, start_addr}.
  function automatic int cfg_width(input int addr_width, input int len_width);
    return 2 + len_width + addr_width;
  endfunction

endpackage

// File: rtl/burst_addr_calc.sv
// Combinational beat address generator and WRAP legality check.
module burst_addr_calc
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 4
) (
  input  mode_t                 mode,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  beat_idx,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  legal
);

  logic [LEN_WIDTH:0]    len_p1;
  logic [ADDR_WIDTH-1:0] len_mask;
  logic [ADDR_WIDTH-1:0] offs_sum;

  // Address for the current beat; WRAP requires len+1 to be a power of two >= 2.
  always_comb begin
    len_p1   = {1'b0, len} + (LEN_WIDTH+1)'(1);
    len_mask = ADDR_WIDTH'(len);
    offs_sum = start_addr + ADDR_WIDTH'(beat_idx);
    legal    = (mode != MODE_WRAP) ||
               ((len != '0) && (({1'b0, len} & len_p1) == '0));
    case (mode)
      MODE_INCR: next_addr = offs_sum;
      MODE_WRAP: next_addr = (start_addr & ~len_mask) | (offs_sum & len_mask);
      default:   next_addr = start_addr;
    endcase
  end

endmodule

// File: rtl/burst_addr_seq.sv
// Burst address sequencer: serial descriptor in, one MSB-first address frame per beat out.
module burst_addr_seq
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic                 cfg_sdi,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 beat_ack,
  output logic                 addr_sdo,
  output logic                 addr_frame,
  output logic [LEN_WIDTH-1:0] beat_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CFG_WIDTH = cfg_width(ADDR_WIDTH, LEN_WIDTH);
  localparam int CNT_W     = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CFG_WIDTH-1:0]  cfg_q;
  mode_t                 cfg_mode;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic [ADDR_WIDTH-1:0] cfg_start;
  logic [ADDR_WIDTH-1:0] calc_addr;
  logic                  calc_legal;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic                  err_q;
  logic                  last_beat;

  // Descriptor field decode and last-beat detection.
  always_comb begin
    cfg_mode  = mode_t'(cfg_q[CFG_WIDTH-1 -: 2]);
    cfg_len   = cfg_q[ADDR_WIDTH +: LEN_WIDTH];
    cfg_start = cfg_q[ADDR_WIDTH-1:0];
    last_beat = (cfg_mode == MODE_SINGLE) || (beat_q == cfg_len);
  end

  burst_addr_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_calc (
    .mode      (cfg_mode),
    .len       (cfg_len),
    .start_addr(cfg_start),
    .beat_idx  (beat_q),
    .next_addr (calc_addr),
    .legal     (calc_legal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && calc_legal) state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == LAST_BIT) state_nxt = ST_WAIT;
      ST_WAIT:  if (beat_ack) state_nxt = last_beat ? ST_DONE : ST_CALC;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Descriptor shift-in, error pulse, beat counter and address shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      addr_sr <= '0;
      bit_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && cfg_en) cfg_q <= {cfg_q[CFG_WIDTH-2:0], cfg_sdi};
      err_q <= (state == ST_IDLE) && start && !calc_legal;
      case (state)
        ST_IDLE: if (state_nxt == ST_CALC) beat_q <= '0;
        ST_CALC: begin
          addr_sr <= calc_addr;
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          addr_sr <= {addr_sr[ADDR_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        ST_WAIT: if (beat_ack && !abort && !last_beat) beat_q <= beat_q + LEN_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; serial data is gated to zero outside a frame.
  always_comb begin
    addr_frame = (state == ST_SHIFT);
    addr_sdo   = addr_frame & addr_sr[ADDR_WIDTH-1];
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    err        = err_q;
    beat_idx   = beat_q;
  end

endmodule

// File: tb/tb_burst_addr_seq.sv
// Directed self-checking bench for burst_addr_seq (ADDR_WIDTH=20, LEN_WIDTH=4).
module tb_burst_addr_seq;

  localparam int AW = 20;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic          cfg_sdi;
  logic          start;
  logic          abort;
  logic          beat_ack;
  logic          addr_sdo;
  logic          addr_frame;
  logic [LW-1:0] beat_idx;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  burst_addr_seq #(
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .cfg_sdi   (cfg_sdi),
    .start     (start),
    .abort     (abort),
    .beat_ack  (beat_ack),
    .addr_sdo  (addr_sdo),
    .addr_frame(addr_frame),
    .beat_idx  (beat_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic load_cfg(input logic [1:0] mode, input logic [3:0] len, input logic [19:0] addr);
    logic [25:0] w;
    w = {mode, len, addr};
    cfg_en = 1'b1;
    for (int i = 25; i >= 0; i--) begin
      cfg_sdi = w[i];
      @(negedge clk);
    end
    cfg_en  = 1'b0;
    cfg_sdi = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the CALC cycle the frame must appear exactly one cycle later.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (!addr_frame && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 1);
  endtask

  task automatic grab(input int nbits, output logic [19:0] a, output int hi);
    a  = '0;
    hi = 0;
    for (int i = 0; i < nbits; i++) begin
      a = {a[18:0], addr_sdo};
      if (addr_frame) hi++;
      @(negedge clk);
    end
  endtask

  task automatic run_burst(input string tag, input int nbeats, input logic [19:0] want [4]);
    logic [19:0] a;
    int          hi;
    pulse_start();
    check({tag, " busy@T+1"}, busy, 1);
    check({tag, " frame@T+1"}, addr_frame, 0);
    for (int b = 0; b < nbeats; b++) begin
      wait_frame($sformatf("%s b%0d", tag, b));
      check($sformatf("%s b%0d beat_idx", tag, b), beat_idx, b);
      grab(AW, a, hi);
      check($sformatf("%s b%0d addr", tag, b), a, want[b]);
      check($sformatf("%s b%0d frame_len", tag, b), hi, AW);
      check($sformatf("%s b%0d frame_end", tag, b), addr_frame, 0);
      beat_ack = 1'b1;
      @(negedge clk);
      beat_ack = 1'b0;
      if (b == nbeats - 1) begin
        check($sformatf("%s done", tag), done, 1);
        @(negedge clk);
        check($sformatf("%s done_pulse", tag), done, 0);
        check($sformatf("%s idle", tag), busy, 0);
      end else begin
        check($sformatf("%s b%0d no_done", tag, b), done, 0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] e [4];
    logic [19:0] a;
    int          hi;
    int          cnt;

    rst      = 1'b1;
    cfg_en   = 1'b0;
    cfg_sdi  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    beat_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst addr_sdo", addr_sdo, 0);
    check("rst addr_frame", addr_frame, 0);
    check("rst beat_idx", beat_idx, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    load_cfg(2'b01, 4'd3, 20'h00010);
    e = '{20'h00010, 20'h00011, 20'h00012, 20'h00013};
    run_burst("incr", 4, e);

    load_cfg(2'b10, 4'd3, 20'h0000E);
    e = '{20'h0000E, 20'h0000F, 20'h0000C, 20'h0000D};
    run_burst("wrap", 4, e);

    load_cfg(2'b01, 4'd3, 20'hFFFFE);
    e = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    run_burst("incr_roll", 4, e);

    load_cfg(2'b11, 4'd2, 20'h12345);
    e = '{20'h12345, 20'h12345, 20'h12345, 20'h00000};
    run_burst("fixed", 3, e);

    load_cfg(2'b00, 4'd7, 20'hABCDE);
    e = '{20'hABCDE, 20'h00000, 20'h00000, 20'h00000};
    run_burst("single", 1, e);

    // Illegal WRAP length: err pulse only, no burst.
    load_cfg(2'b10, 4'd2, 20'h00040);
    pulse_start();
    check("bad_wrap err", err, 1);
    check("bad_wrap busy", busy, 0);
    @(negedge clk);
    check("bad_wrap err_pulse", err, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (addr_frame || busy) cnt++;
      @(negedge clk);
    end
    check("bad_wrap no_frame", cnt, 0);

    // Abort on the 5th bit of the second frame; cfg_en while busy must be ignored.
    load_cfg(2'b01, 4'd3, 20'h00100);
    pulse_start();
    wait_frame("abort b0");
    cfg_en  = 1'b1;
    cfg_sdi = 1'b1;
    grab(AW, a, hi);
    cfg_en  = 1'b0;
    cfg_sdi = 1'b0;
    check("abort b0 addr", a, 20'h00100);
    beat_ack = 1'b1;
    @(negedge clk);
    beat_ack = 1'b0;
    wait_frame("abort b1");
    grab(4, a, hi);
    check("abort pre frame", addr_frame, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort frame", addr_frame, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    check("abort quiet", cnt, 0);

    // Restart without reloading: the descriptor must be intact.
    e = '{20'h00100, 20'h00101, 20'h00102, 20'h00103};
    run_burst("reuse", 4, e);

    // Reset during the second beat.
    pulse_start();
    wait_frame("mrst b0");
    grab(AW, a, hi);
    beat_ack = 1'b1;
    @(negedge clk);
    beat_ack = 1'b0;
    wait_frame("mrst b1");
    check("mrst beat_idx pre", beat_idx, 1);
    grab(3, a, hi);
    rst = 1'b1;
    @(negedge clk);
    check("mrst addr_sdo", addr_sdo, 0);
    check("mrst addr_frame", addr_frame, 0);
    check("mrst beat_idx", beat_idx, 0);
    check("mrst busy", busy, 0);
    check("mrst done", done, 0);
    check("mrst err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst busy after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_addr_seq.md
# burst_addr_seq

Parametrised burst address sequencer: the successor to the fixed 20-bit / 4-bit burst controller. It accepts a serially loaded burst descriptor (mode, length, start address) and generates one address per beat. Addresses are serialised MSB-first toward the MRAM SPI/PTS path. Unlike its predecessor it supports incrementing, wrapping, fixed and single modes, has a per-beat downstream handshake, and provides abort and error reporting.

## Interface
- ADDR_WIDTH, 20, address width in bits
- LEN_WIDTH, 4, burst length field width; beats = len+1
- CFG_WIDTH, 2+LEN_WIDTH+ADDR_WIDTH (derived), descriptor width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_en  in  1  shift enable for cfg_sdi; honoured only in IDLE
- cfg_sdi  in  1  descriptor serial data, MSB first: {mode[1:0], len, start_addr}
- start  in  1  single-cycle pulse, begins burst; ignored unless IDLE
- abort  in  1  terminates burst, returns to IDLE
- beat_ack  in  1  downstream finished current beat; sampled only in WAIT
- addr_sdo  out  1  serial address bit, MSB first
- addr_frame  out  1  high exactly while addr_sdo carries valid bits
- beat_idx  out  LEN_WIDTH  index of current beat
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last beat acknowledged
- err  out  1  one-cycle pulse on rejected descriptor

## Operation
- Modes: 00 SINGLE (one beat, len ignored); 01 INCR (start+i, modulo 2^ADDR_WIDTH); 10 WRAP (base=start & ~len, addr = base | ((start+i) & len)); 11 FIXED (start repeated len+1 times).
- WRAP is legal only when len+1 is a power of two ≥2. Otherwise `start` pulses err, the block stays in IDLE and no frame is produced.
- States: IDLE → CALC on start; CALC (1 cycle, latch address into ADDR_WIDTH shift register) → SHIFT; SHIFT (ADDR_WIDTH cycles, frame high) → WAIT; WAIT → CALC on beat_ack if beats remain, else → DONE; DONE (1 cycle, done=1) → IDLE.
- beat_idx increments on each accepted beat_ack (not last). It is cleared on entering CALC from IDLE.
- Descriptor register holds its value across bursts; start can repeat it without reloading.
- abort in any non-IDLE state: next cycle IDLE, frame/busy low, no done. abort beats beat_ack in the same cycle.
- cfg_en while busy: ignored, descriptor unchanged.

## Timing
- Reset values: addr_sdo=0, addr_frame=0, beat_idx=0, busy=0, done=0, err=0; state IDLE; descriptor register 0.
- start sampled at cycle T: busy at T+1 (CALC), first address bit (MSB) and frame at T+2, LSB at T+1+ADDR_WIDTH.
- beat_ack sampled at cycle A in WAIT: CALC at A+1, next frame starts A+2.
- Last ack at A: done=1 at A+1, busy=0 at A+2.
- err pulses at T+1 for an illegal WRAP start.
- Minimum burst period per beat: ADDR_WIDTH+2 cycles plus ack wait.
- Reset mid-burst: all outputs return to reset values the following cycle.

## Structure
- Package burst_pkg: mode encodings (MODE_SINGLE/INCR/WRAP/FIXED), state enum, CFG_WIDTH helper.
- Sub-module burst_addr_calc: inputs mode, len, start_addr, beat_idx; output next address. Purely combinational. Implements the INCR/WRAP/FIXED rules and the WRAP legality check.
- Top holds the descriptor shift register, FSM, beat counter and output shift register.

## Test plan
Defaults used throughout: ADDR_WIDTH=20, LEN_WIDTH=4.
- Reset: assert rst 3 cycles mid-burst → all outputs 0 next cycle, busy 0.
- INCR, start 0x00010, len 3, immediate acks → frames carry 0x00010, 0x00011, 0x00012, 0x00013; each frame is 20 cycles; done one cycle after 4th ack.
- WRAP, start 0x0000E, len 3 → 0x0000E, 0x0000F, 0x0000C, 0x0000D.
- INCR, start 0xFFFFE, len 3 → 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- FIXED 0x12345, len 2 → three frames of 0x12345. SINGLE, len 7 → one frame, then done.
- WRAP, len 2 → err pulse, no frame, busy stays 0. INCR burst with abort on 5th bit of 2nd frame → frame low next cycle, no done; cfg_en during the burst leaves the descriptor unchanged.
